mdio_peripheral: RTL and testbench
==================================

Name: mdio_peripheral

Overview:
- PHY-side MDIO slave that sits directly downstream of the MDIO controller.
- Consumes the controller's MDC, MDIO_OE and MDIO_OUT, and produces the MDIO_IN returned to the controller.
- Decodes Clause-22 frames (ST, OP, PHYAD, REGAD, TA, DATA) and turns them into single-cycle writes/reads on a 32x16 register-bank interface.
- Runs entirely on the system clock; MDC is treated as a sampled input.

Parameters:
- PHY_ADDR, 5'd1, PHY address this peripheral answers to (used only with MDIO_PHYAD_FILTER_EN).

Ports:
- CLK  input  1  system clock
- RESET  input  1  asynchronous active-low reset
- MDC  input  1  MDIO clock from controller
- MDIO_OE  input  1  controller drives MDIO_OUT when 1
- MDIO_OUT  input  1  serial data from controller
- MDIO_IN  output  1  serial read data to controller
- ADDR  output  5  register address (REGAD of current frame)
- WR_DATA  output  16  write data
- WR_STB  output  1  one-CLK write strobe
- RD_DATA  input  16  register contents at ADDR, combinational from bank
- FRAME_ERR  output  1  one-CLK pulse on bad ST/OP

Behaviour:
- Reset: asynchronous on RESET=0; clock is CLK.
  - All outputs reset to 0; state=IDLE; bit counter=0; mdc_q=0.
- Edge detect: mdc_q registers MDC.
  - rise = MDC & ~mdc_q; fall = ~MDC & mdc_q.
  - All actions occur on the CLK cycle in which rise or fall is detected (one CLK after the MDC transition).
- Bit numbering: bits are numbered 1..32 by MDC rises within a frame, MSB first.
- IDLE:
  - On rise with MDIO_OE=1: shift MDIO_OUT into header register, cnt=1, go to HEADER.
  - Rises with MDIO_OE=0 are ignored.
- HEADER:
  - Shift on each rise until cnt=14.
  - On bit 14, evaluate ST/OP:
    - ST!=01, or OP not in {01,10}: pulse FRAME_ERR, go to DISCARD.
    - OP=01: ADDR<=REGAD, go to WRITE.
    - OP=10: ADDR<=REGAD, go to READ_TA.
- WRITE:
  - Shift bits 15..32 into an 18-bit register (TA bits discarded).
  - On bit 32: WR_DATA<=data[15:0], WR_STB=1 for exactly one CLK, go to IDLE.
  - If MDIO_OE is sampled 0 on any rise before bit 32: abort to IDLE, no strobe.
- READ_TA:
  - Capture RD_DATA into shift register on the CLK after entry (ADDR stable one cycle).
  - Rises 15 and 16 are turnaround.
  - On the fall following rise 15, MDIO_IN=0.
  - On the fall following rise 16, MDIO_IN=data[15], go to READ_DATA.
- READ_DATA:
  - On each fall following rises 17..31, MDIO_IN = next bit (data[14]..data[0]).
  - On the fall following rise 32: MDIO_IN=0, go to IDLE.
  - MDIO_OE is ignored during READ_TA/READ_DATA.
- DISCARD: count rises up to bit 32 regardless of MDIO_OE, then go to IDLE.
- Simultaneous events: rise and fall cannot coincide. Reset overrides everything, including mid-frame; a mid-frame reset clears MDIO_IN immediately.
- ADDR holds its last value between frames. WR_DATA holds its value until the next write.

Optional Feature:
- MDIO_PHYAD_FILTER_EN:
  - Defined: on bit 14, a PHYAD != PHY_ADDR sends the FSM to DISCARD without a FRAME_ERR pulse. No WR_STB is issued, MDIO_IN stays 0, and ADDR is not updated.
  - Undefined: PHYAD is ignored and every well-formed frame is serviced.

Decomposition:
- Package mdio_pkg holds:
  - state encoding (IDLE, HEADER, WRITE, READ_TA, READ_DATA, DISCARD)
  - ST=2'b01, OP_WR=2'b01, OP_RD=2'b10
  - HDR_BITS=14, FRAME_BITS=32, TA_END=16
- Sub-module mdio_regfile: a 32x16 bank with async-low reset to 0, combinational read, written on WR_STB. It is instantiated beside the peripheral in the integration top and bench, not inside it.

Test Plan:
- Write frame {01,01,00001,00010,00,16'h3C33} -> exactly one WR_STB with ADDR=2, WR_DATA=16'h3C33; mdio_regfile[2]=16'h3C33; FRAME_ERR never asserts.
- Preload reg 4=16'hA5C3, send read header {01,10,00011,00100} -> MDIO_IN=0 during TA, then 1010010111000011 on successive MDC periods (each bit valid at the rise); MDIO_IN=0 afterwards; no WR_STB.
- Frame with ST=00 -> FRAME_ERR one-CLK pulse at bit 14, no WR_STB, next valid write accepted normally.
- MDIO_OE dropped after bit 20 of a write -> no WR_STB, FSM in IDLE; following complete write to reg 7 with 16'h1234 succeeds.
- RESET=0 asserted at read data bit 5 -> MDIO_IN=0, WR_STB=0 and FRAME_ERR=0 immediately; after release, a read of reg 4 returns 16'hA5C3 correctly.
- With MDIO_PHYAD_FILTER_EN and PHY_ADDR=1: write to PHYAD=3 -> no WR_STB and no FRAME_ERR; write to PHYAD=1 -> WR_STB.

Source files
------------

// File: rtl/mdio_pkg.sv
// Shared definitions for the Clause-22 MDIO peripheral and its register bank:
// FSM state encoding, frame field codes and bit-position landmarks.
package mdio_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_HEADER    = 3'd1,
    S_WRITE     = 3'd2,
    S_READ_TA   = 3'd3,
    S_READ_DATA = 3'd4,
    S_DISCARD   = 3'd5
  } mdio_state_e;

  localparam logic [1:0] MDIO_ST = 2'b01;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_RD   = 2'b10;

  // Bit positions are MDC-rise numbers within a frame (1-based).
  localparam logic [5:0] HDR_BITS   = 6'd14;
  localparam logic [5:0] FRAME_BITS = 6'd32;
  localparam logic [5:0] TA_END     = 6'd16;

  localparam int unsigned REG_NUM = 32;
  localparam int unsigned DATA_W  = 16;

endpackage

// File: rtl/mdio_regfile.sv
// 32x16 register bank: combinational read at addr_i, written on wr_stb_i,
// cleared by asynchronous active-low reset. Sits beside mdio_peripheral.
module mdio_regfile
  import mdio_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [4:0]        addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              wr_stb_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [REG_NUM];

  // Storage: clear on reset, otherwise accept the single-cycle write strobe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < REG_NUM; i++) begin
        mem_q[i] <= 16'd0;
      end
    end else if (wr_stb_i) begin
      mem_q[addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[addr_i];

endmodule

// File: rtl/mdio_peripheral.sv
// PHY-side Clause-22 MDIO slave. MDC is sampled on CLK; every frame action
// happens on the CLK cycle where an MDC rise or fall is detected.
// Optional build macro MDIO_PHYAD_FILTER_EN: frames whose PHYAD differs from
// PHY_ADDR are silently discarded (no FRAME_ERR, no ADDR update).
module mdio_peripheral
  import mdio_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR = 5'd1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MDC,
  input  logic        MDIO_OE,
  input  logic        MDIO_OUT,
  output logic        MDIO_IN,
  output logic [4:0]  ADDR,
  output logic [15:0] WR_DATA,
  output logic        WR_STB,
  input  logic [15:0] RD_DATA,
  output logic        FRAME_ERR
);

  mdio_state_e state_q, state_d;
  logic        mdc_q;
  logic [5:0]  cnt_q, cnt_d;
  logic [12:0] hdr_q, hdr_d;       // first 13 header bits; bit 14 is taken live
  logic [15:0] wsh_q, wsh_d;       // TA bits shift out the top before data lands
  logic [15:0] rsh_q, rsh_d;
  logic        cap_q, cap_d;
  logic        mdio_in_q, mdio_in_d;
  logic [4:0]  addr_q, addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        wr_stb_q, wr_stb_d;
  logic        frame_err_q, frame_err_d;

  logic        rise_s, fall_s;
  logic [5:0]  cnt_inc_s;
  logic [13:0] hdr_full_s;
  logic [1:0]  st_s, op_s;
  logic [4:0]  phyad_s, regad_s;
  logic        hdr_bad_s, phy_hit_s, phy_drop_s;

  assign rise_s     = MDC & ~mdc_q;
  assign fall_s     = ~MDC & mdc_q;
  assign cnt_inc_s  = cnt_q + 6'd1;
  assign hdr_full_s = {hdr_q, MDIO_OUT};
  assign st_s       = hdr_full_s[13:12];
  assign op_s       = hdr_full_s[11:10];
  assign phyad_s    = hdr_full_s[9:5];
  assign regad_s    = hdr_full_s[4:0];
  assign hdr_bad_s  = (st_s != MDIO_ST) || ((op_s != OP_WR) && (op_s != OP_RD));
  assign phy_hit_s  = (phyad_s == PHY_ADDR);

`ifdef MDIO_PHYAD_FILTER_EN
  assign phy_drop_s = ~phy_hit_s;
`else
  logic unused_phy_hit_s;
  assign unused_phy_hit_s = phy_hit_s;
  assign phy_drop_s       = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode driven by detected MDC edges and the bit counter.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (rise_s && MDIO_OE) state_d = S_HEADER;
        else                   state_d = S_IDLE;
      end
      S_HEADER: begin
        if (rise_s && (cnt_inc_s == HDR_BITS)) begin
          if (hdr_bad_s || phy_drop_s) state_d = S_DISCARD;
          else if (op_s == OP_WR)      state_d = S_WRITE;
          else                         state_d = S_READ_TA;
        end else begin
          state_d = S_HEADER;
        end
      end
      S_WRITE: begin
        if (rise_s && (cnt_inc_s == FRAME_BITS)) state_d = S_IDLE;
        else if (rise_s && !MDIO_OE)             state_d = S_IDLE;
        else                                     state_d = S_WRITE;
      end
      S_READ_TA: begin
        if (fall_s && (cnt_q == TA_END)) state_d = S_READ_DATA;
        else                             state_d = S_READ_TA;
      end
      S_READ_DATA: begin
        if (fall_s && (cnt_q == FRAME_BITS)) state_d = S_IDLE;
        else                                 state_d = S_READ_DATA;
      end
      S_DISCARD: begin
        if (rise_s && (cnt_inc_s == FRAME_BITS)) state_d = S_IDLE;
        else                                     state_d = S_DISCARD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values: shifting, counting, strobes and MDIO_IN.
  always_comb begin
    cnt_d       = cnt_q;
    hdr_d       = hdr_q;
    wsh_d       = wsh_q;
    rsh_d       = rsh_q;
    cap_d       = 1'b0;
    mdio_in_d   = mdio_in_q;
    addr_d      = addr_q;
    wr_data_d   = wr_data_q;
    wr_stb_d    = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rise_s && MDIO_OE) begin
          hdr_d = hdr_full_s[12:0];
          cnt_d = 6'd1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_HEADER: begin
        if (rise_s) begin
          hdr_d = hdr_full_s[12:0];
          cnt_d = cnt_inc_s;
          if (cnt_inc_s == HDR_BITS) begin
            if (hdr_bad_s) begin
              frame_err_d = 1'b1;
            end else if (!phy_drop_s) begin
              addr_d = regad_s;
              cap_d  = (op_s == OP_RD);
            end else begin
              addr_d = addr_q;
            end
          end else begin
            frame_err_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_WRITE: begin
        if (rise_s) begin
          cnt_d = cnt_inc_s;
          wsh_d = {wsh_q[14:0], MDIO_OUT};
          if (cnt_inc_s == FRAME_BITS) begin
            wr_data_d = {wsh_q[14:0], MDIO_OUT};
            wr_stb_d  = 1'b1;
          end else begin
            wr_stb_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_READ_TA: begin
        // ADDR became valid on entry, so the bank output is stable now.
        if (cap_q) rsh_d = RD_DATA;
        else       rsh_d = rsh_q;
        if (rise_s) begin
          cnt_d = cnt_inc_s;
        end else if (fall_s && (cnt_q == TA_END - 6'd1)) begin
          mdio_in_d = 1'b0;
        end else if (fall_s && (cnt_q == TA_END)) begin
          mdio_in_d = rsh_q[15];
          rsh_d     = {rsh_q[14:0], 1'b0};
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_READ_DATA: begin
        if (rise_s) begin
          cnt_d = cnt_inc_s;
        end else if (fall_s && (cnt_q == FRAME_BITS)) begin
          mdio_in_d = 1'b0;
        end else if (fall_s) begin
          mdio_in_d = rsh_q[15];
          rsh_d     = {rsh_q[14:0], 1'b0};
        end else begin
          mdio_in_d = mdio_in_q;
        end
      end
      S_DISCARD: begin
        if (rise_s) cnt_d = cnt_inc_s;
        else        cnt_d = cnt_q;
      end
      default: begin
        cnt_d     = 6'd0;
        mdio_in_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers; asynchronous reset clears MDIO_IN mid-frame.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      mdc_q       <= 1'b0;
      cnt_q       <= 6'd0;
      hdr_q       <= 13'd0;
      wsh_q       <= 16'd0;
      rsh_q       <= 16'd0;
      cap_q       <= 1'b0;
      mdio_in_q   <= 1'b0;
      addr_q      <= 5'd0;
      wr_data_q   <= 16'd0;
      wr_stb_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      mdc_q       <= MDC;
      cnt_q       <= cnt_d;
      hdr_q       <= hdr_d;
      wsh_q       <= wsh_d;
      rsh_q       <= rsh_d;
      cap_q       <= cap_d;
      mdio_in_q   <= mdio_in_d;
      addr_q      <= addr_d;
      wr_data_q   <= wr_data_d;
      wr_stb_q    <= wr_stb_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign MDIO_IN   = mdio_in_q;
  assign ADDR      = addr_q;
  assign WR_DATA   = wr_data_q;
  assign WR_STB    = wr_stb_q;
  assign FRAME_ERR = frame_err_q;

endmodule

// File: tb/tb_mdio_peripheral.sv
// Directed bench for mdio_peripheral with an mdio_regfile beside it.
module tb_mdio_peripheral;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        rf_rst_n = 1'b0;
  logic        MDC = 1'b0;
  logic        MDIO_OE = 1'b0;
  logic        MDIO_OUT = 1'b0;
  wire         MDIO_IN;
  wire  [4:0]  ADDR;
  wire  [15:0] WR_DATA;
  wire         WR_STB;
  wire  [15:0] RD_DATA;
  wire         FRAME_ERR;

  int pass_cnt = 0;
  int total_cnt = 0;
  int stb_cnt = 0;
  int err_cnt = 0;
  int err_bit = 0;
  int cur_bit = 0;
  logic [4:0]  stb_addr = 5'd0;
  logic [15:0] stb_data = 16'd0;

`ifdef MDIO_PHYAD_FILTER_EN
  localparam logic [4:0] RD_PHY = 5'd1;
`else
  localparam logic [4:0] RD_PHY = 5'd3;
`endif

  always #5 CLK = ~CLK;

  mdio_peripheral #(.PHY_ADDR(5'd1)) dut (
    .CLK(CLK), .RESET(RESET), .MDC(MDC), .MDIO_OE(MDIO_OE), .MDIO_OUT(MDIO_OUT),
    .MDIO_IN(MDIO_IN), .ADDR(ADDR), .WR_DATA(WR_DATA), .WR_STB(WR_STB),
    .RD_DATA(RD_DATA), .FRAME_ERR(FRAME_ERR)
  );

  mdio_regfile u_rf (
    .clk_i(CLK), .rst_ni(rf_rst_n), .addr_i(ADDR), .wr_data_i(WR_DATA),
    .wr_stb_i(WR_STB), .rd_data_o(RD_DATA)
  );

  // Pulse monitor: counts strobe/error cycles and records what they carried.
  always @(negedge CLK) begin
    if (WR_STB === 1'b1) begin
      stb_cnt  <= stb_cnt + 1;
      stb_addr <= ADDR;
      stb_data <= WR_DATA;
    end
    if (FRAME_ERR === 1'b1) begin
      err_cnt <= err_cnt + 1;
      err_bit <= cur_bit;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] mk(input logic [1:0] st, input logic [1:0] op,
                                     input logic [4:0] phy, input logic [4:0] rg,
                                     input logic [15:0] d);
    return {st, op, phy, rg, 2'b10, d};
  endfunction

  // One MDC period; 'seen' is MDIO_IN just before the rise.
  task automatic mdc_bit(input logic oe, input logic d, output logic seen);
    MDIO_OE  = oe;
    MDIO_OUT = d;
    repeat (4) @(negedge CLK);
    seen = MDIO_IN;
    MDC  = 1'b1;
    repeat (4) @(negedge CLK);
    MDC  = 1'b0;
  endtask

  // Full 32-bit frame plus one idle MDC period to observe MDIO_IN afterwards.
  task automatic frame(input logic [31:0] bits, input logic rd, input int oe_drop,
                       output logic [15:0] rdv, output logic ta_bad, output logic post);
    logic s;
    logic oe;
    rdv = 16'd0;
    ta_bad = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      cur_bit = k;
      if (k <= 14) oe = 1'b1;
      else if (rd) oe = 1'b0;
      else oe = (k <= oe_drop);
      mdc_bit(oe, bits[32-k], s);
      if (k == 15 || k == 16) ta_bad = ta_bad | (s !== 1'b0);
      if (k >= 17) rdv[32-k] = s;
    end
    cur_bit = 0;
    mdc_bit(1'b0, 1'b0, post);
    repeat (4) @(negedge CLK);
  endtask

  task automatic test_reset;
    RESET = 1'b0;
    rf_rst_n = 1'b0;
    repeat (3) @(negedge CLK);
    total_cnt++; if (MDIO_IN !== 1'b0) $display("FAIL reset_mdio_in: got %b want 0", MDIO_IN); else pass_cnt++;
    total_cnt++; if (ADDR !== 5'd0) $display("FAIL reset_addr: got %h want 0", ADDR); else pass_cnt++;
    total_cnt++; if (WR_DATA !== 16'd0) $display("FAIL reset_wr_data: got %h want 0", WR_DATA); else pass_cnt++;
    total_cnt++; if (WR_STB !== 1'b0) $display("FAIL reset_wr_stb: got %b want 0", WR_STB); else pass_cnt++;
    total_cnt++; if (FRAME_ERR !== 1'b0) $display("FAIL reset_frame_err: got %b want 0", FRAME_ERR); else pass_cnt++;
    RESET = 1'b1;
    rf_rst_n = 1'b1;
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_write;
    int s0, e0;
    logic [15:0] rdv;
    logic tab, post;
    s0 = stb_cnt; e0 = err_cnt;
    frame(mk(2'b01, 2'b01, 5'd1, 5'd2, 16'h3C33), 1'b0, 32, rdv, tab, post);
    total_cnt++; if (stb_cnt - s0 !== 1) $display("FAIL write_stb_count: got %0d want 1", stb_cnt - s0); else pass_cnt++;
    total_cnt++; if (stb_addr !== 5'd2) $display("FAIL write_addr: got %h want 02", stb_addr); else pass_cnt++;
    total_cnt++; if (stb_data !== 16'h3C33) $display("FAIL write_data: got %h want 3c33", stb_data); else pass_cnt++;
    total_cnt++; if (RD_DATA !== 16'h3C33) $display("FAIL write_regfile2: got %h want 3c33", RD_DATA); else pass_cnt++;
    total_cnt++; if (err_cnt - e0 !== 0) $display("FAIL write_no_err: got %0d want 0", err_cnt - e0); else pass_cnt++;
    frame(mk(2'b01, 2'b01, 5'd1, 5'd4, 16'hA5C3), 1'b0, 32, rdv, tab, post);
    total_cnt++; if (RD_DATA !== 16'hA5C3) $display("FAIL write_regfile4: got %h want a5c3", RD_DATA); else pass_cnt++;
  endtask

  task automatic test_read;
    int s0;
    logic [15:0] rdv;
    logic tab, post;
    s0 = stb_cnt;
    frame(mk(2'b01, 2'b10, RD_PHY, 5'd4, 16'h0000), 1'b1, 32, rdv, tab, post);
    total_cnt++; if (tab !== 1'b0) $display("FAIL read_ta: got %b want 0", tab); else pass_cnt++;
    total_cnt++; if (rdv !== 16'hA5C3) $display("FAIL read_data: got %h want a5c3", rdv); else pass_cnt++;
    total_cnt++; if (post !== 1'b0) $display("FAIL read_post: got %b want 0", post); else pass_cnt++;
    total_cnt++; if (stb_cnt - s0 !== 0) $display("FAIL read_no_stb: got %0d want 0", stb_cnt - s0); else pass_cnt++;
    total_cnt++; if (ADDR !== 5'd4) $display("FAIL read_addr: got %h want 04", ADDR); else pass_cnt++;
  endtask

  task automatic test_frame_err;
    int s0, e0;
    logic [15:0] rdv;
    logic tab, post;
    s0 = stb_cnt; e0 = err_cnt;
    frame(mk(2'b00, 2'b01, 5'd1, 5'd5, 16'hFFFF), 1'b0, 32, rdv, tab, post);
    total_cnt++; if (err_cnt - e0 !== 1) $display("FAIL ferr_pulse_cycles: got %0d want 1", err_cnt - e0); else pass_cnt++;
    total_cnt++; if (err_bit !== 14) $display("FAIL ferr_bit: got %0d want 14", err_bit); else pass_cnt++;
    total_cnt++; if (stb_cnt - s0 !== 0) $display("FAIL ferr_no_stb: got %0d want 0", stb_cnt - s0); else pass_cnt++;
    frame(mk(2'b01, 2'b01, 5'd1, 5'd5, 16'h0F0F), 1'b0, 32, rdv, tab, post);
    total_cnt++; if (stb_cnt - s0 !== 1) $display("FAIL ferr_next_stb: got %0d want 1", stb_cnt - s0); else pass_cnt++;
    total_cnt++; if (stb_data !== 16'h0F0F) $display("FAIL ferr_next_data: got %h want 0f0f", stb_data); else pass_cnt++;
  endtask

  task automatic test_write_abort;
    int s0;
    logic [15:0] rdv;
    logic tab, post;
    s0 = stb_cnt;
    frame(mk(2'b01, 2'b01, 5'd1, 5'd6, 16'hBEEF), 1'b0, 20, rdv, tab, post);
    total_cnt++; if (stb_cnt - s0 !== 0) $display("FAIL abort_no_stb: got %0d want 0", stb_cnt - s0); else pass_cnt++;
    total_cnt++; if (RD_DATA !== 16'h0000) $display("FAIL abort_reg6: got %h want 0000", RD_DATA); else pass_cnt++;
    frame(mk(2'b01, 2'b01, 5'd1, 5'd7, 16'h1234), 1'b0, 32, rdv, tab, post);
    total_cnt++; if (stb_cnt - s0 !== 1) $display("FAIL abort_next_stb: got %0d want 1", stb_cnt - s0); else pass_cnt++;
    total_cnt++; if (stb_addr !== 5'd7) $display("FAIL abort_next_addr: got %h want 07", stb_addr); else pass_cnt++;
    total_cnt++; if (stb_data !== 16'h1234) $display("FAIL abort_next_data: got %h want 1234", stb_data); else pass_cnt++;
  endtask

  task automatic test_reset_mid_read;
    logic [31:0] bits;
    logic [15:0] rdv;
    logic s, tab, post;
    bits = mk(2'b01, 2'b10, RD_PHY, 5'd4, 16'h0000);
    for (int k = 1; k <= 21; k++) begin
      mdc_bit((k <= 14), bits[32-k], s);
    end
    repeat (4) @(negedge CLK);
    total_cnt++; if (MDIO_IN !== 1'b1) $display("FAIL midread_bit10: got %b want 1", MDIO_IN); else pass_cnt++;
    MDIO_OE = 1'b0;
    #2 RESET = 1'b0;
    #1;
    total_cnt++; if (MDIO_IN !== 1'b0) $display("FAIL midreset_mdio_in: got %b want 0", MDIO_IN); else pass_cnt++;
    total_cnt++; if (WR_STB !== 1'b0) $display("FAIL midreset_wr_stb: got %b want 0", WR_STB); else pass_cnt++;
    total_cnt++; if (FRAME_ERR !== 1'b0) $display("FAIL midreset_frame_err: got %b want 0", FRAME_ERR); else pass_cnt++;
    total_cnt++; if (ADDR !== 5'd0) $display("FAIL midreset_addr: got %h want 0", ADDR); else pass_cnt++;
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    frame(bits, 1'b1, 32, rdv, tab, post);
    total_cnt++; if (rdv !== 16'hA5C3) $display("FAIL postreset_read: got %h want a5c3", rdv); else pass_cnt++;
    total_cnt++; if (tab !== 1'b0) $display("FAIL postreset_ta: got %b want 0", tab); else pass_cnt++;
  endtask

  task automatic test_phyad;
    int s0, e0;
    logic [15:0] rdv;
    logic tab, post;
    s0 = stb_cnt; e0 = err_cnt;
    frame(mk(2'b01, 2'b01, 5'd3, 5'd9, 16'h5A5A), 1'b0, 32, rdv, tab, post);
`ifdef MDIO_PHYAD_FILTER_EN
    total_cnt++; if (stb_cnt - s0 !== 0) $display("FAIL phy_other_stb: got %0d want 0", stb_cnt - s0); else pass_cnt++;
    total_cnt++; if (err_cnt - e0 !== 0) $display("FAIL phy_other_err: got %0d want 0", err_cnt - e0); else pass_cnt++;
    total_cnt++; if (ADDR !== 5'd4) $display("FAIL phy_other_addr: got %h want 04", ADDR); else pass_cnt++;
    frame(mk(2'b01, 2'b01, 5'd1, 5'd9, 16'h5A5A), 1'b0, 32, rdv, tab, post);
`endif
    total_cnt++; if (stb_cnt - s0 !== 1) $display("FAIL phy_stb: got %0d want 1", stb_cnt - s0); else pass_cnt++;
    total_cnt++; if (stb_data !== 16'h5A5A) $display("FAIL phy_data: got %h want 5a5a", stb_data); else pass_cnt++;
    total_cnt++; if (err_cnt - e0 !== 0) $display("FAIL phy_err: got %0d want 0", err_cnt - e0); else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_frame_err;
    test_write_abort;
    test_reset_mid_read;
    test_phyad;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
